// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - memory-side request/ready bus shared by the arbiter and the memory model
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface mem_port_arbiter_if #(
  parameter int W = `WORD_WIDTH
);
  logic         m_req;
  logic         m_we;
  logic [W-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic         m_ready;
  logic [W-1:0] m_rdata;

  // arbiter side: issues requests, receives completion and read data
  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_rdata
  );

  // memory side: accepts requests, returns completion and read data
  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port memory; optional counters under ARB_STATS_EN
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int W        = `WORD_WIDTH,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [W-1:0]         i_addr,
  output logic                 i_ack,
  output logic [W-1:0]         i_rdata,
  input  logic                 d_load_en,
  input  logic                 d_store_en,
  input  logic [W-1:0]         d_addr,
  input  logic [W-1:0]         d_wdata,
  output logic                 d_ack,
  output logic [W-1:0]         d_rdata,
  mem_port_arbiter_if.master   mem,
  output logic                 busy,
  output logic [W-1:0]         stat_i_grants,
  output logic [W-1:0]         stat_d_grants,
  output logic [W-1:0]         stat_wait_cycles
);

  typedef enum logic [1:0] {IDLE, MEM, ACK} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state, state_nxt;
  logic             d_req;
  logic             grant_i, grant_d;
  logic             owner_d;
  logic [CNT_W-1:0] starve_cnt;

  assign d_req = d_load_en | d_store_en;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // arbitration and next-state: data wins ties unless fetch has lost MAX_WAIT times in a row
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || starve_cnt == MAX_CNT)) grant_i = 1'b1;
        else if (d_req)                                  grant_d = 1'b1;
        if (grant_i || grant_d) state_nxt = MEM;
      end
      MEM:     if (mem.m_ready) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // memory bus, read-data capture and completion pulses; rst abandons any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.m_req   <= 1'b0;
      mem.m_we    <= 1'b0;
      mem.m_addr  <= '0;
      mem.m_wdata <= '0;
      owner_d     <= 1'b0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      busy        <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      busy  <= (state_nxt != IDLE);
      if (grant_i || grant_d) begin
        owner_d     <= grant_d;
        mem.m_req   <= 1'b1;
        mem.m_we    <= grant_d & d_store_en;
        mem.m_addr  <= grant_d ? d_addr : i_addr;
        mem.m_wdata <= d_wdata;
      end else if (state == MEM && mem.m_ready) begin
        mem.m_req <= 1'b0;
        mem.m_we  <= 1'b0;
        if (owner_d) begin
          d_ack <= 1'b1;
          // stores complete without touching the load result register
          if (!mem.m_we) d_rdata <= mem.m_rdata;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= mem.m_rdata;
        end
      end
    end
  end

  // fetch starvation counter: counts data wins over a waiting fetch, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req && starve_cnt != MAX_CNT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  // grant and contention counters, wrapping at 2^W
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_grants    <= '0;
      stat_d_grants    <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (grant_i) stat_i_grants <= stat_i_grants + 1'b1;
      if (grant_d) stat_d_grants <= stat_d_grants + 1'b1;
      if (state != IDLE && (owner_d ? i_req : d_req))
        stat_wait_cycles <= stat_wait_cycles + 1'b1;
    end
  end
`else
  assign stat_i_grants    = '0;
  assign stat_d_grants    = '0;
  assign stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_load_en;
  logic        d_store_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        busy;
  logic [31:0] stat_i_grants;
  logic [31:0] stat_d_grants;
  logic [31:0] stat_wait_cycles;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter_if #(.W(32)) mbus ();

  mem_port_arbiter #(.W(32), .MAX_WAIT(4), .CNT_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_req            (i_req),
    .i_addr           (i_addr),
    .i_ack            (i_ack),
    .i_rdata          (i_rdata),
    .d_load_en        (d_load_en),
    .d_store_en       (d_store_en),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_ack            (d_ack),
    .d_rdata          (d_rdata),
    .mem              (mbus.master),
    .busy             (busy),
    .stat_i_grants    (stat_i_grants),
    .stat_d_grants    (stat_d_grants),
    .stat_wait_cycles (stat_wait_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lone transaction with m_ready=1 in the first MEM cycle; starts from IDLE
  task automatic txn(input bit ld, input bit st, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input string tag);
    logic        is_d;
    logic [31:0] prev_d;
    is_d   = ld | st;
    prev_d = d_rdata;
    if (is_d) begin
      d_load_en  = ld;
      d_store_en = st;
      d_addr     = addr;
      d_wdata    = wdata;
    end else begin
      i_req  = 1'b1;
      i_addr = addr;
    end
    mbus.m_ready = 1'b1;
    mbus.m_rdata = rdata;
    tick();
    check({tag, ".m_req"},  {31'd0, mbus.m_req}, 32'd1);
    check({tag, ".m_we"},   {31'd0, mbus.m_we},  {31'd0, st});
    check({tag, ".m_addr"}, mbus.m_addr, addr);
    check({tag, ".busy"},   {31'd0, busy}, 32'd1);
    tick();
    check({tag, ".i_ack"},  {31'd0, i_ack}, {31'd0, ~is_d});
    check({tag, ".d_ack"},  {31'd0, d_ack}, {31'd0, is_d});
    check({tag, ".m_req_off"}, {31'd0, mbus.m_req}, 32'd0);
    if (is_d) check({tag, ".d_rdata"}, d_rdata, st ? prev_d : rdata);
    else      check({tag, ".i_rdata"}, i_rdata, rdata);
    i_req = 1'b0; d_load_en = 1'b0; d_store_en = 1'b0;
    tick();
    check({tag, ".ack_end"}, {30'd0, i_ack, d_ack}, 32'd0);
    check({tag, ".idle"},    {31'd0, busy}, 32'd0);
  endtask

  bit          exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] exp_ig, exp_dg;

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_load_en = 1'b0; d_store_en = 1'b0;
    d_addr = '0; d_wdata = '0; mbus.m_ready = 1'b0; mbus.m_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst.busy",    {31'd0, busy}, 32'd0);
    check("rst.m_req",   {31'd0, mbus.m_req}, 32'd0);
    check("rst.acks",    {30'd0, i_ack, d_ack}, 32'd0);
    check("rst.i_rdata", i_rdata, 32'd0);
    check("rst.d_rdata", d_rdata, 32'd0);
    check("rst.m_addr",  mbus.m_addr, 32'd0);
    tick();

    txn(1'b0, 1'b0, 32'h0040_0000, 32'd0, 32'h2408_0005, "fetch");

    d_store_en = 1'b1; d_addr = 32'h1000_0010; d_wdata = 32'hDEAD_BEEF;
    mbus.m_ready = 1'b0; mbus.m_rdata = 32'h1234_5678;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("store.m_we",    {31'd0, mbus.m_we}, 32'd1);
      check("store.m_addr",  mbus.m_addr, 32'h1000_0010);
      check("store.m_wdata", mbus.m_wdata, 32'hDEAD_BEEF);
      check("store.no_ack",  {31'd0, d_ack}, 32'd0);
      if (c == 3) mbus.m_ready = 1'b1;
    end
    tick();
    check("store.d_ack",   {31'd0, d_ack}, 32'd1);
    check("store.d_rdata", d_rdata, 32'd0);
    d_store_en = 1'b0;
    tick();
    check("store.ack_end", {31'd0, d_ack}, 32'd0);

    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_load_en = 1'b1; d_addr = 32'h0000_0200;
    mbus.m_ready = 1'b1; mbus.m_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("prio%0d.m_addr", k), mbus.m_addr, exp_d[k] ? 32'h0000_0200 : 32'h0000_0100);
      tick();
      check($sformatf("prio%0d.acks", k), {30'd0, i_ack, d_ack}, exp_d[k] ? 32'd1 : 32'd2);
      tick();
    end
    i_req = 1'b0; d_load_en = 1'b0;
    tick();

    d_load_en = 1'b1; d_addr = 32'h0000_0300; mbus.m_ready = 1'b0;
    tick();
    check("rstmem.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; d_load_en = 1'b0;
    tick();
    check("rstmem.busy_off",  {31'd0, busy}, 32'd0);
    check("rstmem.m_req_off", {31'd0, mbus.m_req}, 32'd0);
    check("rstmem.no_ack",    {31'd0, d_ack}, 32'd0);
    rst = 1'b0;
    tick();
    check("rstmem.no_ack2",   {31'd0, d_ack}, 32'd0);
    txn(1'b0, 1'b0, 32'h0040_0004, 32'd0, 32'hCAFE_F00D, "postrst");

    txn(1'b1, 1'b1, 32'h1000_0020, 32'h0BAD_F00D, 32'h7777_7777, "ldst");
    txn(1'b0, 1'b0, 32'h0040_0008, 32'd0, 32'h0000_1111, "fetch2");
    txn(1'b0, 1'b0, 32'h0040_000C, 32'd0, 32'h0000_2222, "fetch3");
    txn(1'b1, 1'b0, 32'h1000_0024, 32'd0, 32'h8888_9999, "load");

`ifdef ARB_STATS_EN
    exp_ig = 32'd3; exp_dg = 32'd2;
`else
    exp_ig = 32'd0; exp_dg = 32'd0;
`endif
    check("stat_i_grants",    stat_i_grants, exp_ig);
    check("stat_d_grants",    stat_d_grants, exp_dg);
    check("stat_wait_cycles", stat_wait_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
